mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port 512x32 system RAM between the CPU memory path (MAR/MDR strobes from
//   control_unit) and a debug/loader port (program download, memory inspection). It sits between
//   those requesters and the RAM instance. It sequences each access as issue / read-wait / ack.
//   Fixed CPU priority is bounded by a starvation counter, so the debug port always progresses.
// PARAMETERS
//   ADDR_W       9   RAM word-address width
//   DATA_W       32  RAM data width
//   MAX_CPU_RUN  4   max consecutive CPU grants while dbg is pending (>=1)
// PORTS
//   clk            in   1       system clock (divided clock domain); all logic on rising edge
//   in_reset       in   1       asynchronous, active-low reset
//   in_cpu_req     in   1       CPU access request, level; held until out_cpu_ack
//   in_cpu_we      in   1       1 = write, 0 = read
//   in_cpu_addr    in   ADDR_W  CPU word address
//   in_cpu_wdata   in   DATA_W  CPU write data
//   out_cpu_ack    out  1       one-cycle pulse: CPU access complete
//   out_cpu_rdata  out  DATA_W  CPU read data; valid with ack, held until next CPU read ack
//   out_cpu_stall  out  1       in_cpu_req & ~out_cpu_ack (combinational; gates control_unit)
//   in_dbg_req / in_dbg_we / in_dbg_addr / in_dbg_wdata   in   as CPU equivalents, debug port
//   out_dbg_ack / out_dbg_rdata                           out  as CPU equivalents, debug port
//   out_mem_address  out  ADDR_W  RAM address
//   out_mem_data     out  DATA_W  RAM write data
//   out_mem_rden     out  1       RAM read enable
//   out_mem_wren     out  1       RAM write enable
//   in_mem_q         in   DATA_W  RAM read data; valid the cycle after the rden edge
//   out_owner        out  2       00 = none, 01 = CPU, 10 = debug (current grant)
// BEHAVIOUR
//   Reset (async, in_reset=0): FSM is IDLE. All acks, rden, wren, rdata, mem address/data,
//     out_owner and cpu_streak are 0. This applies at once, including mid-access; the access is dropped.
//   FSM is IDLE -> ISSUE -> {write: DONE | read: CAPT -> DONE} -> IDLE.
//   IDLE: arbitrate on the current in_*_req. On a grant, register the winner's we/addr/wdata and
//     owner, then go to ISSUE. With no request, stay in IDLE with owner 00.
//   Arbitration: a single requester wins. When both request, CPU wins unless cpu_streak == MAX_CPU_RUN;
//     in that case dbg wins. On a CPU grant with dbg_req=1, cpu_streak increments (saturating).
//     On a CPU grant with dbg_req=0, or on any dbg grant, cpu_streak clears.
//   ISSUE (1 cycle): registered request drives out_mem_address/data. wren=we, rden=~we; never both.
//   CAPT (reads only): sample in_mem_q into the owner's rdata register at end of cycle.
//   DONE: the owner's ack is high for exactly this cycle; owner returns to 00 on exit.
//   Latency, with the grant in IDLE at cycle 0: write ack in cycle 2, read ack in cycle 3.
//     Max throughput is one write per 3 cycles or one read per 4 cycles.
//   Requester rule: drop req in the cycle after ack. A req still high in IDLE is a new request.
//   Request fields are sampled at grant only; later changes do not affect the access in flight.
//   rden/wren are 0 in every state except ISSUE. out_mem_address/data hold their last value.
//   The non-owner's ack and rdata never change during the owner's access.
// TESTING
//   1 Reset during read ISSUE cycle -> rden drops at once; no ack; FSM IDLE, rdata 0, owner 00.
//   2 CPU write 0x005<=0xDEADBEEF, then read 0x005 -> write ack cyc 2; read ack cyc 3, rdata 0xDEADBEEF.
//   3 Debug alone reads 0x1FF preloaded 0x12345678 -> dbg ack cyc 3, dbg_rdata 0x12345678, CPU rdata unchanged.
//   4 Both requesting back-to-back, MAX_CPU_RUN=4 -> grant order C,C,C,C,D,C,C,C,C,D.
//   5 Requester changes wdata 0xAAAA->0x5555 during ISSUE -> RAM holds 0xAAAA.
//   6 Dbg writes 0x010<=0xCAFEF00D while CPU waits; CPU then reads 0x010 -> 0xCAFEF00D; stall high until CPU ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port system RAM between the CPU memory path and the debug/loader port.
// Each access runs IDLE -> ISSUE -> (CAPT for reads) -> DONE; CPU priority is bounded by a streak limit.
module mem_port_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic              clk,
  input  logic              in_reset,
  input  logic              in_cpu_req,
  input  logic              in_cpu_we,
  input  logic [ADDR_W-1:0] in_cpu_addr,
  input  logic [DATA_W-1:0] in_cpu_wdata,
  output logic              out_cpu_ack,
  output logic [DATA_W-1:0] out_cpu_rdata,
  output logic              out_cpu_stall,
  input  logic              in_dbg_req,
  input  logic              in_dbg_we,
  input  logic [ADDR_W-1:0] in_dbg_addr,
  input  logic [DATA_W-1:0] in_dbg_wdata,
  output logic              out_dbg_ack,
  output logic [DATA_W-1:0] out_dbg_rdata,
  output logic [ADDR_W-1:0] out_mem_address,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              out_mem_rden,
  output logic              out_mem_wren,
  input  logic [DATA_W-1:0] in_mem_q,
  output logic [1:0]        out_owner
);

  localparam int STREAK_W = $clog2(MAX_CPU_RUN + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_RUN);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_win;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v == STREAK_MAX) ? STREAK_MAX : v + 1'b1;
  endfunction

  // CPU loses a contested slot only once it has used up its run of consecutive grants.
  assign cpu_win = in_cpu_req & ~(in_dbg_req & (streak_q == STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    streak_d    = streak_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_win) begin
          owner_d  = OWN_CPU;
          we_d     = in_cpu_we;
          addr_d   = in_cpu_addr;
          wdata_d  = in_cpu_wdata;
          streak_d = in_dbg_req ? sat_inc(streak_q) : '0;
          state_d  = S_ISSUE;
        end else if (in_dbg_req) begin
          owner_d  = OWN_DBG;
          we_d     = in_dbg_we;
          addr_d   = in_dbg_addr;
          wdata_d  = in_dbg_wdata;
          streak_d = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = we_q ? S_DONE : S_CAPT;
      S_CAPT: begin
        if (owner_q == OWN_CPU) cpu_rdata_d = in_mem_q;
        else                    dbg_rdata_d = in_mem_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      streak_q    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      streak_q    <= streak_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Strobes and acks decode from state so an async reset kills them in the same instant.
  assign out_mem_rden    = (state_q == S_ISSUE) & ~we_q;
  assign out_mem_wren    = (state_q == S_ISSUE) &  we_q;
  assign out_mem_address = addr_q;
  assign out_mem_data    = wdata_q;
  assign out_cpu_ack     = (state_q == S_DONE) & (owner_q == OWN_CPU);
  assign out_dbg_ack     = (state_q == S_DONE) & (owner_q == OWN_DBG);
  assign out_cpu_rdata   = cpu_rdata_q;
  assign out_dbg_rdata   = dbg_rdata_q;
  assign out_cpu_stall   = in_cpu_req & ~out_cpu_ack;
  assign out_owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a RAM model on the memory port, a transaction-level
// reference model compared every cycle, plus hand-computed expectations per scenario.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MAXR = 4;

  logic          clk = 1'b0;
  logic          in_reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          cpu_ack, cpu_stall, dbg_ack, mem_rden, mem_wren;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_data;
  logic [DW-1:0] mem_q = '0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    owner;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_RUN(MAXR)) dut (
    .clk(clk), .in_reset(in_reset),
    .in_cpu_req(cpu_req), .in_cpu_we(cpu_we), .in_cpu_addr(cpu_addr), .in_cpu_wdata(cpu_wdata),
    .out_cpu_ack(cpu_ack), .out_cpu_rdata(cpu_rdata), .out_cpu_stall(cpu_stall),
    .in_dbg_req(dbg_req), .in_dbg_we(dbg_we), .in_dbg_addr(dbg_addr), .in_dbg_wdata(dbg_wdata),
    .out_dbg_ack(dbg_ack), .out_dbg_rdata(dbg_rdata),
    .out_mem_address(mem_addr), .out_mem_data(mem_data),
    .out_mem_rden(mem_rden), .out_mem_wren(mem_wren),
    .in_mem_q(mem_q), .out_owner(owner)
  );

  // Synchronous single-port RAM with a backdoor write used for preloading.
  logic [DW-1:0] ram [512];
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wren) ram[mem_addr] <= mem_data;
    if (mem_rden) mem_q <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one access at a time, described by its cycle index since grant.
  logic          m_busy = 1'b0;
  int            m_t = 0, m_lat = 0, m_streak = 0;
  logic [1:0]    m_own = 2'b00;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0, e_crd = '0, e_drd = '0;
  logic [DW-1:0] ref_mem [512];

  always @(posedge clk or negedge in_reset) begin
    if (bd_we) ref_mem[bd_addr] <= bd_data;
    if (!in_reset) begin
      m_busy <= 1'b0; m_t <= 0; m_streak <= 0; m_own <= 2'b00;
      e_addr <= '0; e_data <= '0; e_crd <= '0; e_drd <= '0;
    end else if (m_busy) begin
      if (m_t == m_lat) m_busy <= 1'b0;
      m_t <= m_t + 1;
      if (m_t == 1 && m_we) ref_mem[m_addr] <= m_wdata;
      if (m_t == 2 && !m_we) begin
        if (m_own == 2'b01) e_crd <= ref_mem[m_addr];
        else                e_drd <= ref_mem[m_addr];
      end
    end else if (cpu_req && !(dbg_req && m_streak == MAXR)) begin
      m_busy <= 1'b1; m_t <= 1; m_own <= 2'b01; m_we <= cpu_we;
      m_addr <= cpu_addr; m_wdata <= cpu_wdata; m_lat <= cpu_we ? 2 : 3;
      e_addr <= cpu_addr; e_data <= cpu_wdata;
      m_streak <= dbg_req ? m_streak + 1 : 0;
    end else if (dbg_req) begin
      m_busy <= 1'b1; m_t <= 1; m_own <= 2'b10; m_we <= dbg_we;
      m_addr <= dbg_addr; m_wdata <= dbg_wdata; m_lat <= dbg_we ? 2 : 3;
      e_addr <= dbg_addr; e_data <= dbg_wdata;
      m_streak <= 0;
    end
  end

  logic x_wren, x_rden, x_cack, x_dack, x_stall;
  logic [1:0] x_owner;
  assign x_owner = m_busy ? m_own : 2'b00;
  assign x_wren  = m_busy && m_t == 1 && m_we;
  assign x_rden  = m_busy && m_t == 1 && !m_we;
  assign x_cack  = m_busy && m_t == m_lat && m_own == 2'b01;
  assign x_dack  = m_busy && m_t == m_lat && m_own == 2'b10;
  assign x_stall = cpu_req && !x_cack;

  always @(negedge clk) begin
    chk("owner", 32'(owner), 32'(x_owner));
    chk("wren", 32'(mem_wren), 32'(x_wren));
    chk("rden", 32'(mem_rden), 32'(x_rden));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_data", mem_data, e_data);
    chk("cpu_ack", 32'(cpu_ack), 32'(x_cack));
    chk("dbg_ack", 32'(dbg_ack), 32'(x_dack));
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dbg_rdata", dbg_rdata, e_drd);
    chk("cpu_stall", 32'(cpu_stall), 32'(x_stall));
  end

  // Starts in an IDLE cycle (cycle 0), returns the ack cycle (-1 on timeout), ends in the next IDLE.
  task automatic access(input bit dbg, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit chg, input logic [DW-1:0] d2,
                        output int ack_cyc, output logic [DW-1:0] rd);
    int cyc = 0;
    bit got = 0;
    if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    while (!got && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (chg && cyc == 1) begin
        if (dbg) dbg_wdata = d2; else cpu_wdata = d2;
      end
      if ((dbg ? dbg_ack : cpu_ack) === 1'b1) got = 1;
    end
    ack_cyc = got ? cyc : -1;
    rd = dbg ? dbg_rdata : cpu_rdata;
    if (dbg) dbg_req = 0; else cpu_req = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, nc, nd, dcyc;
    logic [DW-1:0] rd;
    int order [10];
    int exp_order [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    bit got;

    @(posedge clk); #1;
    bd_we = 1; bd_addr = 9'h1FF; bd_data = 32'h12345678;
    @(posedge clk); #1;
    bd_we = 0;
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_rden", 32'(mem_rden), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    #3 in_reset = 1;
    @(posedge clk); #1;

    // CPU write then read of the same word
    access(0, 1, 9'h005, 32'hDEADBEEF, 0, 0, cyc, rd);
    chk("t2_wr_ack_cyc", 32'(cyc), 32'd2);
    access(0, 0, 9'h005, 32'h0, 0, 0, cyc, rd);
    chk("t2_rd_ack_cyc", 32'(cyc), 32'd3);
    chk("t2_rd_data", rd, 32'hDEADBEEF);

    // Debug reads the preloaded top word
    access(1, 0, 9'h1FF, 32'h0, 0, 0, cyc, rd);
    chk("t3_ack_cyc", 32'(cyc), 32'd3);
    chk("t3_dbg_rdata", rd, 32'h12345678);
    chk("t3_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);

    // Reset during the ISSUE cycle of a CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
    @(posedge clk); #1;
    chk("t1_rden_issue", 32'(mem_rden), 32'd1);
    #2 in_reset = 0;
    #1;
    chk("t1_rden_drop", 32'(mem_rden), 32'd0);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_cpu_rdata", cpu_rdata, 32'd0);
    chk("t1_dbg_rdata", dbg_rdata, 32'd0);
    cpu_req = 0;
    @(posedge clk); #1;
    chk("t1_no_ack", 32'(cpu_ack), 32'd0);
    #3 in_reset = 1;
    @(posedge clk); #1;

    // wdata changes after grant must not reach the RAM
    access(0, 1, 9'h020, 32'h0000AAAA, 1, 32'h00005555, cyc, rd);
    chk("t5_ack_cyc", 32'(cyc), 32'd2);
    chk("t5_ram", ram[9'h020], 32'h0000AAAA);
    access(0, 0, 9'h020, 32'h0, 0, 0, cyc, rd);
    chk("t5_readback", rd, 32'h0000AAAA);

    // Both ports requesting continuously: starvation bound forces a debug slot every fifth grant
    cpu_req = 1; cpu_we = 1; cpu_addr = 9'h030; cpu_wdata = 32'h1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h031; dbg_wdata = 32'h2;
    n = 0; nc = 0; nd = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (cpu_ack && n < 10) begin order[n] = 1; n++; nc++; if (nc == 8) cpu_req = 0; end
      if (dbg_ack && n < 10) begin order[n] = 2; n++; nd++; if (nd == 2) dbg_req = 0; end
    end
    cpu_req = 0; dbg_req = 0;
    chk("t4_grants", 32'(n), 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("t4_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    @(posedge clk); #1;

    // Debug write while the CPU waits, then the CPU reads it back
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h010; dbg_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    cyc = 1; dcyc = -1; got = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    #1;
    chk("t6_stall_start", 32'(cpu_stall), 32'd1);
    while (!got && cyc < 30) begin
      @(posedge clk); #1; cyc++;
      if (dbg_ack) begin dcyc = cyc; dbg_req = 0; end
      if (cpu_ack) got = 1;
      else chk("t6_stall_wait", 32'(cpu_stall), 32'd1);
    end
    chk("t6_dbg_ack_cyc", 32'(dcyc), 32'd2);
    chk("t6_cpu_ack_cyc", 32'(got ? cyc : -1), 32'd6);
    chk("t6_stall_at_ack", 32'(cpu_stall), 32'd0);
    chk("t6_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
    cpu_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
